// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: trap cause codes, trap FSM states and trap-value select codes
package trap_ctrl_pkg;

    localparam logic [3:0] EXC_IFETCH_MISAL = 4'd0;
    localparam logic [3:0] EXC_IFETCH_FAULT = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL      = 4'd2;
    localparam logic [3:0] EXC_EBREAK       = 4'd3;
    localparam logic [3:0] EXC_LD_MISAL     = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_ST_MISAL     = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT     = 4'd7;
    localparam logic [3:0] EXC_ECALL        = 4'd11;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, REDIR, RET, HALT} trap_state_t;

    // Source of mtval for the selected exception
    typedef enum logic [1:0] {TVAL_ADDR, TVAL_INSTR, TVAL_PC, TVAL_ZERO} tval_sel_t;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// trap_prio_enc: picks the highest-priority exception flag, its cause code and mtval source
module trap_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic       exc_ifetch_fault,
    input  logic       exc_illegal,
    input  logic       exc_ifetch_misal,
    input  logic       exc_ecall,
    input  logic       exc_ebreak,
    input  logic       exc_st_misal,
    input  logic       exc_ld_misal,
    input  logic       exc_st_fault,
    input  logic       exc_ld_fault,
    output logic       any,
    output logic [3:0] cause,
    output tval_sel_t  tval_sel
);

    // Fixed priority chain, first listed flag wins
    always_comb begin
        any      = 1'b1;
        cause    = EXC_IFETCH_MISAL;
        tval_sel = TVAL_ADDR;
        if (exc_ifetch_fault) begin
            cause = EXC_IFETCH_FAULT;
        end else if (exc_illegal) begin
            cause    = EXC_ILLEGAL;
            tval_sel = TVAL_INSTR;
        end else if (exc_ifetch_misal) begin
            cause = EXC_IFETCH_MISAL;
        end else if (exc_ecall) begin
            cause    = EXC_ECALL;
            tval_sel = TVAL_ZERO;
        end else if (exc_ebreak) begin
            cause    = EXC_EBREAK;
            tval_sel = TVAL_PC;
        end else if (exc_st_misal) begin
            cause = EXC_ST_MISAL;
        end else if (exc_ld_misal) begin
            cause = EXC_LD_MISAL;
        end else if (exc_st_fault) begin
            cause = EXC_ST_FAULT;
        end else if (exc_ld_fault) begin
            cause = EXC_LD_FAULT;
        end else begin
            any = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences exception traps and MRET into the CSR file and redirects the pipeline
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic [31:0]           ex_instr,
    input  logic [DATA_WIDTH-1:0] ex_addr,
    input  logic                  exc_ifetch_fault,
    input  logic                  exc_illegal,
    input  logic                  exc_ifetch_misal,
    input  logic                  exc_ecall,
    input  logic                  exc_ebreak,
    input  logic                  exc_st_misal,
    input  logic                  exc_ld_misal,
    input  logic                  exc_st_fault,
    input  logic                  exc_ld_fault,
    input  logic                  mret_valid,
    input  logic [DATA_WIDTH-1:0] mepc,
    output logic                  trap,
    output logic [3:0]            trap_cause,
    output logic [DATA_WIDTH-1:0] trap_value,
    output logic [DATA_WIDTH-1:0] trap_pc,
    input  logic                  trap_handled,
    input  logic [DATA_WIDTH-1:0] trap_target_pc,
    output logic                  stall,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  fatal,
    output logic [31:0]           trap_count
);

    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    trap_state_t           state_q, state_d;
    logic                  trap_q, trap_d, flush_q, flush_d, stall_q, stall_d;
    logic                  redirect_valid_q, redirect_valid_d, fatal_q, fatal_d;
    logic [3:0]            trap_cause_q, trap_cause_d;
    logic [DATA_WIDTH-1:0] trap_value_q, trap_value_d, trap_pc_q, trap_pc_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]           trap_count_q, trap_count_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;

    logic                  exc_any;
    logic [3:0]            exc_cause;
    tval_sel_t             exc_sel;
    logic [DATA_WIDTH-1:0] exc_tval;

    trap_prio_enc u_prio (
        .exc_ifetch_fault (exc_ifetch_fault),
        .exc_illegal      (exc_illegal),
        .exc_ifetch_misal (exc_ifetch_misal),
        .exc_ecall        (exc_ecall),
        .exc_ebreak       (exc_ebreak),
        .exc_st_misal     (exc_st_misal),
        .exc_ld_misal     (exc_ld_misal),
        .exc_st_fault     (exc_st_fault),
        .exc_ld_fault     (exc_ld_fault),
        .any              (exc_any),
        .cause            (exc_cause),
        .tval_sel         (exc_sel)
    );

    assign exc_tval = (exc_sel == TVAL_INSTR) ? DATA_WIDTH'(ex_instr) :
                      (exc_sel == TVAL_PC)    ? ex_pc :
                      (exc_sel == TVAL_ZERO)  ? {DATA_WIDTH{1'b0}} : ex_addr;

    // Next state plus next value of every registered output (outputs follow the state being entered)
    always_comb begin
        state_d          = state_q;
        trap_d           = 1'b0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        trap_cause_d     = trap_cause_q;
        trap_value_d     = trap_value_q;
        trap_pc_d        = trap_pc_q;
        trap_count_d     = trap_count_q;
        wait_cnt_d       = wait_cnt_q;
        fatal_d          = fatal_q;
        case (state_q)
            IDLE: begin
                if (ex_valid && exc_any) begin
                    state_d      = REQ;
                    trap_d       = 1'b1;
                    flush_d      = 1'b1;
                    trap_cause_d = exc_cause;
                    trap_value_d = exc_tval;
                    trap_pc_d    = ex_pc;
                end else if (mret_valid) begin
                    state_d          = RET;
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = mepc & ALIGN_MASK;
                end
            end
            REQ: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                if (trap_handled) begin
                    state_d          = REDIR;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = trap_target_pc & ALIGN_MASK;
                    trap_count_d     = trap_count_q + 32'd1;
                end else if (wait_cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    state_d = HALT;
                    fatal_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            REDIR, RET: state_d = IDLE;
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
        stall_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            trap_q           <= 1'b0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            trap_cause_q     <= '0;
            trap_value_q     <= '0;
            trap_pc_q        <= '0;
            trap_count_q     <= '0;
            wait_cnt_q       <= '0;
            fatal_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            trap_q           <= trap_d;
            flush_q          <= flush_d;
            stall_q          <= stall_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            trap_cause_q     <= trap_cause_d;
            trap_value_q     <= trap_value_d;
            trap_pc_q        <= trap_pc_d;
            trap_count_q     <= trap_count_d;
            wait_cnt_q       <= wait_cnt_d;
            fatal_q          <= fatal_d;
        end
    end

    assign trap           = trap_q;
    assign trap_cause     = trap_cause_q;
    assign trap_value     = trap_value_q;
    assign trap_pc        = trap_pc_q;
    assign stall          = stall_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign fatal          = fatal_q;
    assign trap_count     = trap_count_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized trap/MRET sequences checked against a cycle-level model
module tb_trap_ctrl;

    localparam int T = 15;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid = 1'b0, mret_valid = 1'b0, trap_handled = 1'b0;
    logic [31:0] ex_pc = '0, ex_instr = '0, ex_addr = '0, mepc = '0, trap_target_pc = '0;
    logic [8:0]  fl = '0;
    logic        trap, stall, flush, redirect_valid, fatal;
    logic [3:0]  trap_cause;
    logic [31:0] trap_value, trap_pc, redirect_pc, trap_count;

    int          vectors = 0, miscompares = 0;
    logic [31:0] exp_count = '0;
    int unsigned codes [9] = '{1, 2, 0, 11, 3, 6, 4, 7, 5};

    trap_ctrl #(.DATA_WIDTH(32), .ACK_TIMEOUT(T)) dut (
        .clk (clk), .rst_n (rst_n), .ex_valid (ex_valid), .ex_pc (ex_pc),
        .ex_instr (ex_instr), .ex_addr (ex_addr),
        .exc_ifetch_fault (fl[0]), .exc_illegal (fl[1]), .exc_ifetch_misal (fl[2]),
        .exc_ecall (fl[3]), .exc_ebreak (fl[4]), .exc_st_misal (fl[5]),
        .exc_ld_misal (fl[6]), .exc_st_fault (fl[7]), .exc_ld_fault (fl[8]),
        .mret_valid (mret_valid), .mepc (mepc), .trap (trap), .trap_cause (trap_cause),
        .trap_value (trap_value), .trap_pc (trap_pc), .trap_handled (trap_handled),
        .trap_target_pc (trap_target_pc), .stall (stall), .flush (flush),
        .redirect_valid (redirect_valid), .redirect_pc (redirect_pc), .fatal (fatal),
        .trap_count (trap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_trap"}, trap, 0);
        chk({tag, "_cause"}, trap_cause, 0);
        chk({tag, "_value"}, trap_value, 0);
        chk({tag, "_pc"}, trap_pc, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_rvalid"}, redirect_valid, 0);
        chk({tag, "_rpc"}, redirect_pc, 0);
        chk({tag, "_fatal"}, fatal, 0);
        chk({tag, "_count"}, trap_count, 0);
    endtask

    // Reference: first set flag in priority order gives the cause; mtval follows the cause kind
    function automatic void model(input logic [8:0] f, input logic [31:0] pc, instr, addr,
                                  output logic [3:0] c, output logic [31:0] v);
        bit found = 0;
        c = 0;
        for (int i = 0; i < 9; i++)
            if (f[i] && !found) begin
                c = 4'(codes[i]);
                found = 1;
            end
        v = (c == 2) ? instr : (c == 3) ? pc : (c == 11) ? 32'h0 : addr;
    endfunction

    task automatic run_trap(input logic [8:0] f, input logic [31:0] pc, instr, addr, tgt,
                            input int dly, input logic with_mret);
        logic [3:0]  ec;
        logic [31:0] ev;
        model(f, pc, instr, addr, ec, ev);
        ex_valid = 1; fl = f; ex_pc = pc; ex_instr = instr; ex_addr = addr;
        mret_valid = with_mret; mepc = $urandom; trap_handled = 0;
        @(negedge clk);
        ex_valid = 0; fl = 0; mret_valid = 0;
        trap_handled = 1; trap_target_pc = $urandom;
        chk("req_trap", trap, 1);
        chk("req_flush", flush, 1);
        chk("req_stall", stall, 1);
        chk("req_rvalid", redirect_valid, 0);
        chk("req_cause", trap_cause, ec);
        chk("req_value", trap_value, ev);
        chk("req_pc", trap_pc, pc);
        @(negedge clk);
        trap_handled = 0;
        for (int i = 0; i <= dly; i++) begin
            chk("wait_stall", stall, 1);
            chk("wait_trap", trap, 0);
            chk("wait_flush", flush, 0);
            chk("wait_rvalid", redirect_valid, 0);
            if (i == dly) begin
                trap_handled = 1; trap_target_pc = tgt;
                ex_valid = 0; fl = 0; mret_valid = 0;
            end else begin
                ex_valid = 1; fl = 9'($urandom_range(1, 511)); mret_valid = 1'($urandom);
            end
            @(negedge clk);
        end
        trap_handled = 0;
        exp_count = exp_count + 32'd1;
        chk("redir_valid", redirect_valid, 1);
        chk("redir_pc", redirect_pc, tgt & ~32'h3);
        chk("redir_count", trap_count, exp_count);
        chk("redir_stall", stall, 1);
        chk("hold_cause", trap_cause, ec);
        chk("hold_value", trap_value, ev);
        @(negedge clk);
        chk("done_stall", stall, 0);
        chk("done_rvalid", redirect_valid, 0);
        chk("done_flush", flush, 0);
    endtask

    task automatic run_mret(input logic [31:0] m);
        mret_valid = 1; mepc = m; ex_valid = 1'($urandom); fl = 0; trap_handled = 0;
        @(negedge clk);
        mret_valid = 0; ex_valid = 0;
        chk("ret_rvalid", redirect_valid, 1);
        chk("ret_pc", redirect_pc, m & ~32'h3);
        chk("ret_flush", flush, 1);
        chk("ret_stall", stall, 1);
        chk("ret_trap", trap, 0);
        @(negedge clk);
        chk("ret_idle_stall", stall, 0);
        chk("ret_idle_rvalid", redirect_valid, 0);
    endtask

    task automatic idle_noise();
        ex_valid = 0; fl = 9'($urandom); mret_valid = 0;
        trap_handled = 1'($urandom); trap_target_pc = $urandom;
        @(negedge clk);
        chk("noise_stall", stall, 0);
        chk("noise_trap", trap, 0);
        chk("noise_rvalid", redirect_valid, 0);
        fl = 0; trap_handled = 0;
    endtask

    initial begin
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1;
        @(negedge clk);

        run_trap(9'h002, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h203, 0, 0);
        run_trap(9'h048, 32'h180, 32'h0000_0073, 32'h1001, 32'h3000, 1, 0);
        run_trap(9'h040, 32'h184, 32'h0000_2003, 32'h1001, 32'h3000, 2, 0);
        run_mret(32'h0000_0446);
        run_trap(9'h010, 32'h2A0, 32'h0010_0073, 32'h55, 32'h4007, 0, 1);

        for (int n = 0; n < 14; n++) begin
            idle_noise();
            if ($urandom_range(0, 3) == 0) run_mret($urandom);
            else run_trap(9'($urandom_range(1, 511)), $urandom, $urandom, $urandom, $urandom,
                          int'($urandom_range(0, 5)), 1'($urandom));
        end

        ex_valid = 1; fl = 9'h100; ex_pc = 32'h700; ex_addr = 32'h88;
        @(negedge clk);
        ex_valid = 0; fl = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk_zero("rst_wait");
        @(negedge clk);
        rst_n = 1;
        exp_count = 0;
        run_trap(9'h020, 32'h900, 32'h0, 32'h123, 32'h808, 1, 0);

        force dut.trap_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.trap_count_q;
        exp_count = 32'hFFFF_FFFE;
        chk("preload_count", trap_count, exp_count);
        run_trap(9'h080, 32'hA00, 32'h0, 32'hBEE0, 32'hC000, 0, 0);
        run_trap(9'h004, 32'hA10, 32'h0, 32'hBEE2, 32'hC100, 3, 0);

        ex_valid = 1; fl = 9'h001; ex_pc = 32'hD00; ex_addr = 32'h40;
        @(negedge clk);
        ex_valid = 0; fl = 0;
        chk("to_req_trap", trap, 1);
        @(negedge clk);
        chk("to_w_fatal", fatal, 0);
        for (int k = 1; k <= T + 3; k++) begin
            @(negedge clk);
            chk("to_fatal", fatal, 32'(k >= T));
            chk("to_stall", stall, 1);
            chk("to_rvalid", redirect_valid, 0);
            if (k > T) trap_handled = 1;
        end
        chk("to_count", trap_count, exp_count);
        trap_handled = 0;
        #2 rst_n = 0;
        #1 chk_zero("rst_halt");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
